// File: rtl/debug_pkg.sv
// debug_pkg: shared constants and state encoding for the MIPS debug step unit.
// Optional feature macro: DEBUG_FRAME_CKSUM_EN (appends an XOR checksum byte to each frame).
package debug_pkg;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 5;
  localparam int NB_BYTE = 8;

  localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h73;  // 's'
  localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h72;  // 'r'
  localparam logic [NB_BYTE-1:0] CMD_HALT = 8'h68;  // 'h'

`ifdef DEBUG_FRAME_CKSUM_EN
  localparam int FRAME_LEN = 6;
`else
  localparam int FRAME_LEN = 5;
`endif

  // Byte index width; 3 bits covers both the 5- and 6-byte frames.
  localparam int IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STEP    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_GAP     = 3'd4,
    ST_RUN     = 3'd5
  } state_t;

endpackage

// File: rtl/debug_step_unit_if.sv
// debug_step_unit_if: UART receive/transmit handshake seen by the debug unit.
// slave = debug unit side, master = UART side.
interface debug_step_unit_if;
  import debug_pkg::*;

  logic [NB_BYTE-1:0] rx_data;
  logic               rx_valid;
  logic               tx_busy;
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_start;

  modport slave  (input  rx_data, rx_valid, tx_busy, output tx_data, tx_start);
  modport master (output rx_data, rx_valid, tx_busy, input  tx_data, tx_start);
endinterface

// File: rtl/debug_frame_tx.sv
// debug_frame_tx: captures the processor outputs on i_load and streams them
// as a byte frame (address byte, then result MSB first, optional checksum).
// Optional feature macro: DEBUG_FRAME_CKSUM_EN.
module debug_frame_tx
  import debug_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_resultado,
  input  logic [NB_ADDR-1:0] i_direccion,
  input  logic               i_tx_busy,
  output logic               o_tx_start,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_done
);

  state_t             r_state;
  logic [NB_ADDR-1:0] r_addr;
  logic [NB_DATA-1:0] r_res;
  logic [IDX_W-1:0]   r_idx;
  logic [NB_BYTE-1:0] w_frame [FRAME_LEN];
  logic               w_last;

  assign w_frame[0] = {{(NB_BYTE-NB_ADDR){1'b0}}, r_addr};

  genvar gi;
  generate
    for (gi = 0; gi < NB_DATA/NB_BYTE; gi++) begin : g_res_bytes
      assign w_frame[gi+1] = r_res[NB_DATA-1-NB_BYTE*gi -: NB_BYTE];
    end
  endgenerate

`ifdef DEBUG_FRAME_CKSUM_EN
  logic [NB_BYTE-1:0] r_cksum;
  logic [NB_BYTE-1:0] w_cksum;

  assign w_cksum = {{(NB_BYTE-NB_ADDR){1'b0}}, i_direccion}
                 ^ i_resultado[31:24] ^ i_resultado[23:16]
                 ^ i_resultado[15:8]  ^ i_resultado[7:0];
  assign w_frame[FRAME_LEN-1] = r_cksum;

  // Checksum is taken from the same inputs as the capture registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cksum <= '0;
    end else if (i_load) begin
      r_cksum <= w_cksum;
    end
  end
`endif

  assign w_last     = (r_idx == IDX_W'(FRAME_LEN-1));
  assign o_tx_start = (r_state == ST_SEND) && !i_tx_busy;
  assign o_tx_data  = o_tx_start ? w_frame[r_idx] : '0;
  assign o_done     = (r_state == ST_GAP) && w_last;

  // Capture on load, then alternate SEND (wait for idle tx) and GAP per byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_res   <= '0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_state <= ST_SEND;
      r_addr  <= i_direccion;
      r_res   <= i_resultado;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_SEND: if (!i_tx_busy) r_state <= ST_GAP;
        ST_GAP: begin
          if (w_last) begin
            r_state <= ST_IDLE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= ST_SEND;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/debug_step_unit.sv
// debug_step_unit: decodes UART step/run/halt commands, drives the MIPS step
// input and sends a captured result frame after each step or halt.
// Optional feature macro: DEBUG_FRAME_CKSUM_EN (checksum byte, handled in debug_frame_tx).
module debug_step_unit
  import debug_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  debug_step_unit_if.slave   uart,
  input  logic [NB_DATA-1:0] i_resultado,
  input  logic [NB_ADDR-1:0] i_direccion,
  output logic               o_step,
  output logic [15:0]        o_step_cnt,
  output logic               o_busy
);

  state_t             r_state;
  logic               r_step;
  logic [15:0]        r_step_cnt;
  logic               w_load;
  logic               w_done;
  logic               w_tx_start;
  logic [NB_BYTE-1:0] w_tx_data;

  assign w_load        = (r_state == ST_CAPTURE);
  assign o_step        = r_step;
  assign o_step_cnt    = r_step_cnt;
  assign o_busy        = (r_state != ST_IDLE);
  assign uart.tx_start = w_tx_start;
  assign uart.tx_data  = w_tx_data;

  // Command decode and step control; SEND covers the whole frame transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_step  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (uart.rx_valid && uart.rx_data == CMD_STEP) begin
            r_state <= ST_STEP;
            r_step  <= 1'b1;
          end else if (uart.rx_valid && uart.rx_data == CMD_RUN) begin
            r_state <= ST_RUN;
            r_step  <= 1'b1;
          end
        end
        ST_STEP: begin
          r_state <= ST_CAPTURE;
          r_step  <= 1'b0;
        end
        ST_RUN: begin
          if (uart.rx_valid && uart.rx_data == CMD_HALT) begin
            r_state <= ST_CAPTURE;
            r_step  <= 1'b0;
          end
        end
        ST_CAPTURE: r_state <= ST_SEND;
        ST_SEND:    if (w_done) r_state <= ST_IDLE;
        default: begin
          r_state <= ST_IDLE;
          r_step  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles with the step output high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step_cnt <= '0;
    end else if (r_step && r_step_cnt != 16'hFFFF) begin
      r_step_cnt <= r_step_cnt + 16'd1;
    end
  end

  debug_frame_tx u_frame_tx (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_resultado(i_resultado),
    .i_direccion(i_direccion),
    .i_tx_busy  (uart.tx_busy),
    .o_tx_start (w_tx_start),
    .o_tx_data  (w_tx_data),
    .o_done     (w_done)
  );

endmodule

// File: doc/debug_step_unit.md
Name: debug_step_unit

Overview:
- Debug controller directly upstream of the MIPS top; drives the processor's `i_step` and consumes its `o_resultado`/`o_direccion`.
- Decodes single-byte commands from the UART receiver: step, run, halt.
- After each step, and after a halt, it captures the processor outputs and streams them to the UART transmitter as a byte frame.

Parameters:
- NB_DATA, 32, width of the captured result.
- NB_ADDR, 5, width of the captured register address.
- NB_BYTE, 8, UART byte width.
- CMD_STEP, 8'h73, ASCII 's', single step.
- CMD_RUN, 8'h72, ASCII 'r', continuous run.
- CMD_HALT, 8'h68, ASCII 'h', stop run.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_rx_data  in  8  received command byte.
- i_rx_valid  in  1  one-cycle pulse; i_rx_data valid.
- i_tx_busy  in  1  transmitter busy; high from the cycle after a start pulse until the byte is sent.
- o_tx_data  out  8  byte to transmit, valid while o_tx_start is high.
- o_tx_start  out  1  one-cycle transmit request.
- i_resultado  in  NB_DATA  MIPS o_resultado.
- i_direccion  in  NB_ADDR  MIPS o_direccion.
- o_step  out  1  to MIPS i_step; processor advances one cycle per high cycle.
- o_step_cnt  out  16  number of cycles o_step has been high since reset; saturating.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state = IDLE
  - o_step = 0, o_tx_start = 0, o_tx_data = 0
  - o_step_cnt = 0, o_busy = 0
  - capture registers = 0
- States: IDLE, STEP, CAPTURE, SEND, GAP, RUN.
- IDLE:
  - i_rx_valid with CMD_STEP -> STEP.
  - i_rx_valid with CMD_RUN -> RUN.
  - Any other byte, including CMD_HALT, is ignored.
- STEP: o_step=1 for exactly one cycle -> CAPTURE.
- CAPTURE: o_step=0; registers i_resultado and i_direccion this cycle, one cycle after the step pulse -> SEND with byte index 0.
- Frame: 5 bytes in this order:
  - byte 0: {3'b000, addr}
  - bytes 1-4: result[31:24], [23:16], [15:8], [7:0] (MSB first)
- SEND:
  - Waits while i_tx_busy=1.
  - When i_tx_busy=0: o_tx_start=1 for one cycle with o_tx_data = frame[index] -> GAP.
- GAP:
  - One cycle with o_tx_start=0, so the transmitter's busy can rise.
  - If index was the last byte -> IDLE; else increment index -> SEND.
- RUN:
  - o_step=1 every cycle.
  - i_rx_valid with CMD_HALT: o_step=0 in the following cycle -> CAPTURE, so one final frame is sent.
  - Other bytes are ignored.
- Bytes received in STEP/CAPTURE/SEND/GAP are dropped; there is no command queue.
- i_rx_valid in the same cycle the frame's final GAP returns to IDLE is dropped; commands are accepted only while in IDLE.
- o_step_cnt:
  - Increments on every cycle with o_step=1.
  - Holds at 16'hFFFF; it never wraps.
- Reset mid-frame: frame is aborted immediately; no partial resume after reset release.
- Latencies: CMD_STEP pulse to o_step is 1 cycle; o_step to the first o_tx_start is 2 cycles, given i_tx_busy=0.

Optional Feature:
- Macro: DEBUG_FRAME_CKSUM_EN.
- Defined: frame is 6 bytes; byte 5 is the XOR of bytes 0-4. The GAP after byte 5 returns to IDLE.
- Undefined: frame is 5 bytes; no checksum logic is synthesized.

Decomposition:
- debug_pkg holds:
  - command codes CMD_STEP, CMD_RUN, CMD_HALT
  - state encoding localparams
  - FRAME_LEN (5, or 6 under the macro)
  - byte-index width
- One natural sub-module: debug_frame_tx.
  - Holds the capture registers, the SEND/GAP byte sequencer and the checksum.
  - Handshake: load/start in, done out.
  - The top keeps command decode, the STEP/RUN control and o_step_cnt.

Test Plan:
- Step: release rst, hold i_direccion=5'd9, i_resultado=32'hDEADBEEF, send 8'h73 -> o_step high 1 cycle; o_step_cnt=1; tx bytes 09, DE, AD, BE, EF; o_busy returns 0.
- Busy backpressure: as above, hold i_tx_busy=1 for 20 cycles after byte 0 -> next o_tx_start only after busy falls; no byte lost or duplicated.
- Run/halt: send 8'h72, wait 50 cycles, send 8'h68 -> o_step high continuously, o_step_cnt≈51 (exact count checked against pulse timing), then one 5-byte frame.
- Ignore: send 8'h41 in IDLE, and 8'h73 during SEND -> no o_step, frame unchanged, state returns to IDLE.
- Reset mid-frame: assert rst after byte 2 -> all outputs 0 immediately; no further o_tx_start after release.
- Checksum (macro defined): addr=5'd1, result=32'h00000003 -> bytes 01, 00, 00, 00, 03, 02.
